// File: rtl/ntt_pkg.sv
// Shared constants and FSM state type for the NTT butterfly address controller.
// The controller walks a forward Cooley-Tukey NTT over N coefficients.
package ntt_pkg;

   localparam int N      = 256;
   localparam int Q      = 3329;
   localparam int LAYERS = 7;
   localparam int RD_LAT = 1;
   localparam int BF_LAT = 6;
   localparam int ZETA_W = 7;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/ntt_addr_delay.sv
// DEPTH-stage shift line carrying {valid, addr_a, addr_b} from the read side to
// the write side, so write-back addresses meet the butterfly u/v outputs.
module ntt_addr_delay #(
   parameter int DEPTH = 7,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [AW-1:0] in_addr_a,
   input  logic [AW-1:0] in_addr_b,
   output logic          out_valid,
   output logic [AW-1:0] out_addr_a,
   output logic [AW-1:0] out_addr_b
);
   import ntt_pkg::*;

   logic [DEPTH-1:0] vld;
   logic [AW-1:0]    a_q [DEPTH];
   logic [AW-1:0]    b_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
         end
      end else begin
         vld[0] <= in_valid;
         a_q[0] <= in_valid ? in_addr_a : '0;
         b_q[0] <= in_valid ? in_addr_b : '0;
         for (int k = 1; k < DEPTH; k++) begin
            vld[k] <= vld[k-1];
            a_q[k] <= a_q[k-1];
            b_q[k] <= b_q[k-1];
         end
      end
   end

   assign out_valid  = vld[DEPTH-1];
   assign out_addr_a = vld[DEPTH-1] ? a_q[DEPTH-1] : '0;
   assign out_addr_b = vld[DEPTH-1] ? b_q[DEPTH-1] : '0;

endmodule

// File: rtl/ntt_bf_ctrl.sv
// Read/zeta address sequencer for a forward NTT, one butterfly per cycle, with a
// drain gap of RD_LAT+BF_LAT cycles between layers to avoid read-after-write hazards.
module ntt_bf_ctrl #(
   parameter int ADDR_W = 8,
   parameter int LAYERS = ntt_pkg::LAYERS,
   parameter int RD_LAT = ntt_pkg::RD_LAT,
   parameter int BF_LAT = ntt_pkg::BF_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   output logic [ADDR_W-2:0] zeta_addr,
   output logic              bf_s,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr_a,
   output logic [ADDR_W-1:0] wr_addr_b
);
   import ntt_pkg::*;

   localparam int D  = RD_LAT + BF_LAT;
   localparam int IW = ADDR_W - 1;
   localparam int LW = $clog2(LAYERS);
   localparam int CW = $clog2(D + 1);

   state_t          state, state_d;
   logic [LW-1:0]   layer, layer_d;
   logic [IW-1:0]   bf, bf_d;
   logic [CW-1:0]   cnt, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         layer <= '0;
         bf    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_d;
         layer <= layer_d;
         bf    <= bf_d;
         cnt   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state;
      layer_d = layer;
      bf_d    = bf;
      cnt_d   = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               state_d = ISSUE;
               layer_d = '0;
               bf_d    = '0;
            end
         end
         ISSUE: begin
            bf_d = bf + 1'b1;
            if (bf == {IW{1'b1}}) begin
               state_d = DRAIN;
               cnt_d   = CW'(D);
            end
         end
         DRAIN: begin
            if (cnt == CW'(1)) begin
               if (layer == LW'(LAYERS - 1)) begin
                  state_d = DONE;
               end else begin
                  state_d = ISSUE;
                  layer_d = layer + 1'b1;
                  bf_d    = '0;
               end
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Group g selects the block of 2*len coefficients, offset o the pair inside it.
   logic [ADDR_W-1:0] len, addr_a, addr_b;
   logic [IW-1:0]     grp, off, zeta;
   logic              issue;

   always_comb begin
      len    = {1'b1, {IW{1'b0}}} >> layer;
      grp    = bf >> (IW - int'(layer));
      off    = bf & IW'(len - 1'b1);
      addr_a = ({1'b0, grp} << (ADDR_W - int'(layer))) | {1'b0, off};
      addr_b = addr_a + len;
      zeta   = (IW'(1) << layer) + grp;
   end

   assign issue     = (state == ISSUE);
   assign rd_en     = issue;
   assign rd_addr_a = issue ? addr_a : '0;
   assign rd_addr_b = issue ? addr_b : '0;
   assign zeta_addr = issue ? zeta : '0;
   assign busy      = issue || (state == DRAIN);
   assign bf_s      = busy;
   assign done      = (state == DONE);

   ntt_addr_delay #(
      .DEPTH (D),
      .AW    (ADDR_W)
   ) u_dly (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (rd_en),
      .in_addr_a  (rd_addr_a),
      .in_addr_b  (rd_addr_b),
      .out_valid  (wr_en),
      .out_addr_a (wr_addr_a),
      .out_addr_b (wr_addr_b)
   );

endmodule
